display_sched: RTL and testbench
================================

# display_sched

Frame scheduler and arbiter for the serial 7-segment display path. It generates the serial-bit enable strobe and time-shares the 16-bit BCD display input among four requesters, switching only on frame boundaries so every 32-bit serial frame is coherent. It sits directly upstream of `display_out`, driving its `enable` and `bcd_in`, and cross-checks its `sending_data` for alignment.

## Interface
- `CLK_DIV`, 50: `clk` cycles per serial tick; must be ≥2.
- `FRAME_TICKS`, 162: ticks per frame; must equal the downstream frame period (send interval + 2); must be ≥34.
- `HOLD_FRAMES`, 4: minimum consecutive frames per grant, ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  4  request level, one bit per requester.
- `data_in`  in  64  BCD value of requester i at bits [16i+15:16i].
- `sending_data`  in  1  downstream "bits in flight" flag.
- `enable`  out  1  one-cycle serial tick strobe to downstream.
- `bcd_out`  out  16  BCD value to downstream.
- `grant`  out  4  one-hot current owner, 0 when idle.
- `frame_done`  out  4  one-cycle pulse to the owner at each frame end.
- `sync_err`  out  1  sticky misalignment flag.

## Operation
- Tick divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `enable`=1 exactly when `div_cnt`==CLK_DIV-1.
- Frame counter: `fcnt` advances on each tick and wraps from FRAME_TICKS-1 to 0.
- Boundary event B = `enable` && `fcnt`==FRAME_TICKS-1. All arbitration happens only at B.
- At B, in priority order:
  - **Keep:** the owner is valid, `req[owner]`=1 and `hold_cnt`<HOLD_FRAMES-1. Ownership is kept and `hold_cnt`++.
  - **Re-arbitrate:** otherwise, round-robin search from (last owner+1) mod 4, or from 0 after reset. The first i with `req[i]`=1 wins; `grant`←onehot(i), `hold_cnt`←0.
  - **Idle:** no request is pending. `grant`←0; `bcd_out` keeps its value.
- Whenever a grant is active after B, `bcd_out` ← `data_in` slice of the new owner, sampled at B. Values are refreshed every held frame.
- `frame_done[i]` = B && `grant[i]` (the pre-B owner).
- A requester deasserting `req` mid-frame does not abort the frame. It loses the grant at the next B.
- A last owner that is still requesting after HOLD expires is re-granted only if no other requester is pending. Round-robin order guarantees this.
- `sync_err` compares every cycle: it is set if `sending_data` ≠ (1≤`fcnt`≤32). It is cleared only by reset.

## Timing
- Reset (async assert, sync-style release on `clk`): `div_cnt`=0, `fcnt`=0, `hold_cnt`=0, last owner=3. All outputs are 0.
- The first tick occurs CLK_DIV cycles after reset release. It sees `fcnt`=0, aligned with the downstream counter 0 at the same tick.
- `bcd_out`/`grant` are registered at B and change one cycle after B. They are therefore stable at least CLK_DIV-1 cycles before the downstream frame-start latch tick.
- Frame period = CLK_DIV·FRAME_TICKS cycles. Arbitration latency from a `req` rise is at most HOLD_FRAMES·3 + 1 frames.
- Reset mid-frame aborts immediately. Downstream shares the same `reset`, so both restart aligned.

## Structure
- Shared package `display_pkg`:
  - `NUM_REQ`=4, `BCD_W`=16, `SERIAL_BITS`=32.
  - A function for the round-robin next-index search.
- Sub-module `tick_gen`: the `CLK_DIV` divider producing `enable`.
- Frame counter, arbiter and `sync_err` checker stay in the top level.

## Test plan
All cases use CLK_DIV=2, FRAME_TICKS=40, HOLD_FRAMES=2, with a `display_out` model attached.
- **Single requester:** `req`=0001, slice0=0x1234 → `grant`=0001 after the first B; downstream frame carries the segments of 0x1234; `frame_done[0]` pulses once per 80 cycles.
- **Round-robin:** `req`=1111 with distinct values → owners 0,0,1,1,2,2,3,3,0 over successive frames; `bcd_out` matches each owner.
- **Early drop:** owner 2 drops `req` mid-frame → its frame completes unchanged and it gets its `frame_done`; the next B grants 3 (if requesting) or goes idle with `bcd_out` held.
- **Live update:** owner's `data_in` changes 0x0001→0x0002 mid-frame → the current frame still sends 0x0001; the next held frame sends 0x0002.
- **Misalignment:** force `sending_data`=1 at `fcnt`=35 → `sync_err`=1 next cycle and stays set until reset.
- **Reset mid-frame:** `reset`=0 at `fcnt`=10 → all outputs are 0 immediately; after release, the first `enable` arrives 2 cycles later.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and the round-robin search used by the display frame scheduler.
// Pure combinational helpers; no state.
package display_pkg;

    localparam int NUM_REQ     = 4;
    localparam int BCD_W       = 16;
    localparam int SERIAL_BITS = 32;
    localparam int IDX_W       = $clog2(NUM_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic found;
        idx_t idx;
    } rr_pick_t;

    // Scans from last+1 upwards; descending loop lets the nearest hit overwrite farther ones.
    function automatic rr_pick_t rr_next(input logic [NUM_REQ-1:0] req, input idx_t last);
        rr_pick_t p;
        idx_t     c;
        p = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c = idx_t'((int'(last) + k) % NUM_REQ);
            if (req[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/display_sched_if.sv
// Requester/downstream bundle of the display frame scheduler.
// slave is the scheduler side, master drives requests and observes the outputs.
interface display_sched_if;
    import display_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*BCD_W-1:0] data_in;
    logic                     sending_data;
    logic                     enable;
    logic [BCD_W-1:0]         bcd_out;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       frame_done;
    logic                     sync_err;

    modport slave (
        input  req, data_in, sending_data,
        output enable, bcd_out, grant, frame_done, sync_err
    );

    modport master (
        output req, data_in, sending_data,
        input  enable, bcd_out, grant, frame_done, sync_err
    );

endinterface

// File: rtl/display_sched_tick_gen.sv
// Serial tick divider: enable is a one-cycle strobe every CLK_DIV clocks, first one
// visible CLK_DIV-1 cycles after reset release so the tick lands on edge CLK_DIV.
module tick_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic enable
);

    localparam int           W        = $clog2(CLK_DIV);
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt_q;
    logic [W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign enable = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/display_sched.sv
// Frame scheduler: switches display ownership only at frame boundaries; grant/bcd_out
// update one cycle after the boundary. No backpressure: requesters simply wait for a grant.
module display_sched
    import display_pkg::*;
#(
    parameter int CLK_DIV     = 50,
    parameter int FRAME_TICKS = 162,
    parameter int HOLD_FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset,
    display_sched_if.slave   io
);

    localparam int            FW         = $clog2(FRAME_TICKS);
    localparam int            HW         = $clog2(HOLD_FRAMES) + 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [FW-1:0] BITS_LAST  = FW'(SERIAL_BITS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

    logic               enable;
    logic               boundary;
    logic               keep;
    logic               in_flight;
    rr_pick_t           pick;

    logic [FW-1:0]      fcnt_q,     fcnt_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    idx_t               last_q,     last_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               sync_err_q, sync_err_d;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable)
    );

    always_comb begin
        fcnt_d = fcnt_q;
        if (enable) begin
            fcnt_d = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + 1'b1;
        end
    end

    assign boundary = enable && (fcnt_q == FRAME_LAST);
    assign pick     = rr_next(io.req, last_q);

    // last_q always names the current owner while grant_q is non-zero.
    assign keep = (|grant_q) && io.req[last_q] && (hold_cnt_q < HOLD_LAST);

    always_comb begin
        grant_d    = grant_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        bcd_d      = bcd_q;
        if (boundary) begin
            if (keep) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                bcd_d      = io.data_in[int'(last_q)*BCD_W +: BCD_W];
            end else if (pick.found) begin
                grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick.idx;
                last_d     = pick.idx;
                hold_cnt_d = '0;
                bcd_d      = io.data_in[int'(pick.idx)*BCD_W +: BCD_W];
            end else begin
                grant_d = '0;
            end
        end
    end

    // Downstream shifts its 32 bits while its own counter sits in 1..32.
    assign in_flight  = (fcnt_q != '0) && (fcnt_q <= BITS_LAST);
    assign sync_err_d = sync_err_q | (io.sending_data != in_flight);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q     <= '0;
            hold_cnt_q <= '0;
            last_q     <= idx_t'(NUM_REQ - 1);
            grant_q    <= '0;
            bcd_q      <= '0;
            sync_err_q <= 1'b0;
        end else begin
            fcnt_q     <= fcnt_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            bcd_q      <= bcd_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign io.enable     = enable;
    assign io.grant      = grant_q;
    assign io.bcd_out    = bcd_q;
    assign io.frame_done = boundary ? grant_q : '0;
    assign io.sync_err   = sync_err_q;

endmodule

// File: tb/tb_display_sched.sv
// Randomized and directed checks of display_sched against a frame-level reference model.
module tb_display_sched;

    localparam int CLK_DIV     = 2;
    localparam int FRAME_TICKS = 40;
    localparam int HOLD_FRAMES = 2;
    localparam int FRAME_CYC   = CLK_DIV * FRAME_TICKS;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    display_sched_if dif ();

    display_sched #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (dif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state: cycles since release, current owner (-1 idle), last owner, frames held.
    int          m_n, m_own, m_last, m_hold;
    logic [15:0] m_bcd;
    bit          m_sync;

    logic [3:0]  req_v;
    logic [15:0] dat_v [4];
    bit          force_sd;
    bit          rand_mode;
    bit          b_prev;
    int          fd0_cnt;
    logic [3:0]  owners_q [$];

    function automatic int m_fcnt();
        return (m_n / CLK_DIV) % FRAME_TICKS;
    endfunction

    function automatic bit m_en();
        return (m_n % CLK_DIV) == CLK_DIV - 1;
    endfunction

    function automatic bit m_b();
        return m_en() && (m_fcnt() == FRAME_TICKS - 1);
    endfunction

    function automatic logic [3:0] oh(input int i);
        if (i < 0) return 4'b0000;
        return 4'b0001 << i;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_own  = -1;
        m_last = 3;
        m_hold = 0;
        m_bcd  = 16'h0;
        m_sync = 1'b0;
        b_prev = 1'b0;
    endtask

    task automatic model_boundary();
        int w;
        if (m_own >= 0 && req_v[m_own] && m_hold < HOLD_FRAMES - 1) begin
            m_hold++;
            m_bcd = dat_v[m_own];
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && req_v[(m_last + k) % 4]) w = (m_last + k) % 4;
            end
            if (w >= 0) begin
                m_own  = w;
                m_last = w;
                m_hold = 0;
                m_bcd  = dat_v[w];
            end else begin
                m_own = -1;
            end
        end
    endtask

    // One clock: check outputs at the negedge, drive inputs, advance the model, wait a cycle.
    task automatic step();
        bit ideal;
        if (b_prev) owners_q.push_back(dif.grant);
        if (dif.frame_done[0]) fd0_cnt++;
        check_eq("enable",     64'(dif.enable),     64'(m_en()));
        check_eq("grant",      64'(dif.grant),      64'(oh(m_own)));
        check_eq("bcd_out",    64'(dif.bcd_out),    64'(m_bcd));
        check_eq("frame_done", 64'(dif.frame_done), 64'(m_b() ? oh(m_own) : 4'b0000));
        check_eq("sync_err",   64'(dif.sync_err),   64'(m_sync));
        if (rand_mode) begin
            if ($urandom_range(0, 29) == 0) req_v = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) dat_v[i] = 16'($urandom);
            end
        end
        ideal            = (m_fcnt() >= 1) && (m_fcnt() <= 32);
        dif.req          = req_v;
        dif.data_in      = {dat_v[3], dat_v[2], dat_v[1], dat_v[0]};
        dif.sending_data = force_sd ? !ideal : ideal;
        if (force_sd) m_sync = 1'b1;
        b_prev = m_b();
        if (m_b()) model_boundary();
        m_n++;
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic run_to_fcnt(input int f, input string tag);
        int guard = 0;
        while (m_fcnt() != f && guard < 4 * FRAME_CYC) begin
            step();
            guard++;
        end
        check_eq(tag, 64'(guard < 4 * FRAME_CYC), 64'(1));
    endtask

    // Runs through the next boundary cycle so the DUT now shows the post-boundary state.
    task automatic run_past_b(input string tag);
        int guard = 0;
        while (!m_b() && guard < 2 * FRAME_CYC) begin
            step();
            guard++;
        end
        check_eq(tag, 64'(guard < 2 * FRAME_CYC), 64'(1));
        step();
    endtask

    // Called at a negedge; asserts reset asynchronously mid-cycle and releases at the next negedge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check_eq({tag, "_enable"},     64'(dif.enable),     64'(0));
        check_eq({tag, "_grant"},      64'(dif.grant),      64'(0));
        check_eq({tag, "_bcd"},        64'(dif.bcd_out),    64'(0));
        check_eq({tag, "_frame_done"}, 64'(dif.frame_done), 64'(0));
        check_eq({tag, "_sync_err"},   64'(dif.sync_err),   64'(0));
        force_sd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] exp_rr [9];
        int         cnt;
        exp_rr = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                   4'b0100, 4'b1000, 4'b1000, 4'b0001};
        req_v     = 4'b0000;
        dat_v     = '{16'h0, 16'h0, 16'h0, 16'h0};
        force_sd  = 1'b0;
        rand_mode = 1'b0;
        fd0_cnt   = 0;
        dif.req          = 4'b0000;
        dif.data_in      = '0;
        dif.sending_data = 1'b0;
        @(negedge clk);
        do_reset("rst");

        // Single requester: frame_done[0] from the 2nd boundary on, once per frame.
        req_v    = 4'b0001;
        dat_v[0] = 16'h1234;
        run(5 * FRAME_CYC);
        check_eq("single_fd_pulses", 64'(fd0_cnt), 64'(4));
        check_eq("single_bcd", 64'(dif.bcd_out), 64'(16'h1234));

        // Live update: the frame in progress keeps the value sampled at its boundary.
        run_to_fcnt(20, "live_reach_a");
        dat_v[0] = 16'h0001;
        run_past_b("live_b1");
        check_eq("live_first", 64'(dif.bcd_out), 64'(16'h0001));
        run_to_fcnt(20, "live_reach_b");
        dat_v[0] = 16'h0002;
        check_eq("live_hold", 64'(dif.bcd_out), 64'(16'h0001));
        run_past_b("live_b2");
        check_eq("live_second", 64'(dif.bcd_out), 64'(16'h0002));

        // Round-robin from reset with everyone requesting.
        do_reset("rst_rr");
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) dat_v[i] = 16'hA000 + 16'(i);
        owners_q.delete();
        run(9 * FRAME_CYC + 4);
        check_eq("rr_count", 64'(owners_q.size() >= 9), 64'(1));
        for (int i = 0; i < 9 && i < owners_q.size(); i++) begin
            check_eq($sformatf("rr_owner%0d", i), 64'(owners_q[i]), 64'(exp_rr[i]));
        end

        // Early drop by owner 2, then everyone drops: idle keeps the last value.
        cnt = 0;
        while (!(m_own == 2 && m_fcnt() == 15) && cnt < 10 * FRAME_CYC) begin
            step();
            cnt++;
        end
        check_eq("drop_reach", 64'(cnt < 10 * FRAME_CYC), 64'(1));
        req_v = 4'b1011;
        run_past_b("drop_b");
        check_eq("drop_grant", 64'(dif.grant), 64'(4'b1000));
        run_to_fcnt(15, "idle_reach");
        req_v = 4'b0000;
        run_past_b("idle_b");
        check_eq("idle_grant", 64'(dif.grant), 64'(0));
        check_eq("idle_bcd", 64'(dif.bcd_out), 64'(16'hA003));

        // Random traffic.
        rand_mode = 1'b1;
        run(4000);
        rand_mode = 1'b0;

        // Misalignment at fcnt 35 is sticky.
        req_v = 4'b0100;
        run_to_fcnt(35, "mis_reach");
        force_sd = 1'b1;
        step();
        force_sd = 1'b0;
        check_eq("mis_set", 64'(dif.sync_err), 64'(1));
        run(3 * FRAME_CYC);
        check_eq("mis_sticky", 64'(dif.sync_err), 64'(1));

        // Reset mid-frame while granted; first tick lands on the CLK_DIV-th edge after release.
        run_to_fcnt(10, "mid_reach");
        check_eq("mid_granted", 64'(dif.grant != 4'b0000), 64'(1));
        do_reset("rst_mid");
        cnt = 0;
        while (!dif.enable && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("first_tick_edge", 64'(cnt + 1), 64'(CLK_DIV));
        do_reset("rst_end");
        run(2 * FRAME_CYC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
